alu_muldiv_seq: RTL and testbench

Multi-cycle sequencer for unsigned M-extension ops (MUL, MULHU, DIVU, REMU). It borrows the EX-stage ALU and issues one add or subtract per cycle, running shift-add multiply and restoring divide.
- Sits beside the ALU in EX.
- While it owns the ALU, the EX operand mux selects its alu_a/alu_b/alu_sel.
- Its busy output stalls the pipeline.
- Request and response use valid/ready handshakes.

---
 rtl/alu_muldiv_seq.sv | 156 +++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the EX-stage ALU,
// issuing one add (shift-add multiply) or subtract (restoring divide) per cycle.
module alu_muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            busy,
    output logic            alu_own,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_sel,
    input  logic [XLEN-1:0] alu_out
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and rsp_data is stable while rsp_valid waits.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   acc_q, acc_d;     // hi (multiply) or rem (divide)
    logic [XLEN-1:0]   low_q, low_d;     // lo (multiply) or quo (divide)
    logic [XLEN-1:0]   opnd_q, opnd_d;   // mcand (multiply) or dvs (divide)
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              is_div;
    logic [XLEN-1:0]   sh;
    logic              take;
    logic              carry;
    logic [XLEN-1:0]   acc_nx;
    logic [XLEN-1:0]   low_nx;

    assign is_div    = op_q[1];
    assign req_ready = (state_q == IDLE) && !flush;
    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q == ITER) || (state_q == DONE);
    assign alu_own   = (state_q == ITER);
    assign rsp_data  = res_q;

    assign sh = {acc_q[XLEN-2:0], low_q[XLEN-1]};

    // ALU operand drive depends only on registered state, never on alu_out.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = 3'b000;
        if (state_q == ITER) begin
            if (is_div) begin
                alu_a   = sh;
                alu_b   = opnd_q;
                alu_sel = 3'b001;
            end else begin
                alu_a   = acc_q;
                alu_b   = low_q[0] ? opnd_q : '0;
                alu_sel = 3'b000;
            end
        end
    end

    // One iteration step computed from the borrowed ALU's result.
    always_comb begin
        carry  = (alu_out < acc_q);
        take   = acc_q[XLEN-1] | (sh >= opnd_q);
        acc_nx = {carry, alu_out[XLEN-1:1]};
        low_nx = {alu_out[0], low_q[XLEN-1:1]};
        if (is_div) begin
            acc_nx = take ? alu_out : sh;
            low_nx = {low_q[XLEN-2:0], take};
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        low_d   = low_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    op_d   = req_op;
                    acc_d  = '0;
                    low_d  = req_op[1] ? req_a : req_b;
                    opnd_d = req_op[1] ? req_b : req_a;
                    cnt_d  = '0;
                    if (req_op[1] && (req_b == '0)) begin
                        res_d   = req_op[0] ? req_a : '1;
                        state_d = DONE;
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_nx;
                    low_d = low_nx;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == {CNT_W{1'b1}}) begin
                        // op[0] picks the high/remainder half for MULHU and REMU.
                        res_d   = op_q[0] ? acc_nx : low_nx;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (flush || rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            low_q   <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            low_q   <= low_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: directed and random ops against a plain-arithmetic model,
// with an ALU model closing the borrowed-ALU loop and a queue-based response monitor.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        busy;
    logic        alu_own;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_sel;
    logic [31:0] alu_out;

    alu_muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .alu_own(alu_own),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // EX-stage ALU as the surrounding pipeline provides it.
    always_comb begin
        alu_out = (alu_sel == 3'b001) ? (alu_a - alu_b) : (alu_a + alu_b);
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          own_q[$];
    int          total = 0;
    int          bad = 0;
    logic [1:0]  cur_op = 2'd0;
    int          rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // ---------------- drivers ----------------
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_rsp);
        int n;
        bit dz;
        n = 0;
        dz = op[1] && (b == 0);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL req_accept_timeout actual=req_ready_low required=req_ready_high");
            req_valid = 1'b0;
            return;
        end
        cur_op = op;
        if (expect_rsp) begin
            exp_q.push_back(model(op, a, b));
            lat_q.push_back(cyc + 1 + (dz ? 0 : 32));
            own_q.push_back(dz ? 0 : 32);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!rsp_valid) begin
            total++;
            bad++;
            $display("FAIL rsp_valid_timeout actual=0 required=1");
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        chk("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       rsp_ready = ($urandom_range(0, 1) == 1);
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'b1;
            endcase
        end
    end

    // ---------------- monitor ----------------
    bit seen = 1'b0;
    int own_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
                own_cnt = 0;
            end else begin
                if (!busy) own_cnt = 0;
                if (alu_own) begin
                    own_cnt++;
                    chk("alu_sel_own", {29'd0, alu_sel}, cur_op[1] ? 32'd1 : 32'd0);
                end else begin
                    chk("alu_idle_zero", alu_a | alu_b | {29'd0, alu_sel}, 32'd0);
                end
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp actual=%h required=no_response", rsp_data);
                    end else begin
                        if (!seen) begin
                            chk("latency_cycle", 32'(cyc), 32'(lat_q[0]));
                            chk("alu_own_cycles", 32'(own_cnt), 32'(own_q[0]));
                            seen = 1'b1;
                        end
                        chk("rsp_data", rsp_data, exp_q[0]);
                        chk("busy_in_done", {31'd0, busy}, 32'd1);
                        chk("req_ready_in_done", {31'd0, req_ready}, 32'd0);
                        if (rsp_ready && !flush) begin
                            void'(exp_q.pop_front());
                            void'(lat_q.pop_front());
                            void'(own_q.pop_front());
                            seen = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_alu_own", {31'd0, alu_own}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

        rdy_mode = 2;
        issue(2'd0, 32'd7, 32'd6, 1);
        wait_drain();
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(2'd2, 32'd100, 32'd7, 1);
        issue(2'd3, 32'd100, 32'd7, 1);
        issue(2'd2, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue(2'd3, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue(2'd2, 32'd5, 32'd0, 1);
        issue(2'd3, 32'd5, 32'd0, 1);
        wait_drain();

        // Consumer back-pressure in DONE.
        rdy_mode = 1;
        issue(2'd0, 32'd1234, 32'd5678, 1);
        wait_valid();
        repeat (10) @(negedge clk);
        chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        rdy_mode = 2;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("release_busy", {31'd0, busy}, 32'd0);
        chk("release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("release_req_ready", {31'd0, req_ready}, 32'd1);

        // Flush mid-iteration loses the result.
        issue(2'd2, 32'd1000, 32'd3, 0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_still_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_blocks_accept", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (40) @(negedge clk);
        chk("flush_no_rsp_busy", {31'd0, busy}, 32'd0);

        // Reset mid-iteration.
        issue(2'd0, 32'd99, 32'd77, 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_alu_own", {31'd0, alu_own}, 32'd0);
        chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mid_alu_b", alu_b | {29'd0, alu_sel}, 32'd0);
        chk("rst_mid_rsp_data", rsp_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(2'd0, 32'd3, 32'd5, 1);
        wait_drain();

        // Random traffic with random consumer back-pressure.
        rdy_mode = 0;
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a = $urandom;
            case ($urandom_range(0, 5))
                0:       r_b = 32'd0;
                1:       r_b = 32'($urandom_range(1, 15));
                2:       r_b = 32'h8000_0000 | $urandom;
                default: r_b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) r_a = 32'($urandom_range(0, 255));
            issue(r_op, r_a, r_b, 1);
        end
        rdy_mode = 2;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
